cc_deserializer: RTL and testbench

- Inbound counterpart of the cache controller's line serializer. Accepts a 512-bit cache-line fill from memory as eight 64-bit beats on a valid/ready read-data channel.
- Beats arrive critical-word-first, wrapping from a requested base word. The block reassembles them into natural word order and pushes one 518-bit entry into the line-fill FIFO.
- The FIFO entry format matches the serializer's input format.

---
 rtl/cc_pkg.sv | 17 +
 rtl/cc_line_assembler.sv | 33 +++
 rtl/cc_deserializer.sv | 139 +++++++++++++
 tb/tb_cc_deserializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared constants and state encoding for the cache-line fill deserializer.
// The optional critical-word forwarding outputs are enabled by CC_DESER_CWF_EN.
package cc_pkg;

    localparam int LINE_W   = 512;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = 8;
    localparam int FIFO_W   = 518;
    localparam int BASE_LSB = 515;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_PUSH = 2'd2
    } state_t;

endpackage

// File: rtl/cc_line_assembler.sv
// Word-indexed 512-bit line register: one 64-bit word written per enabled cycle.
module cc_line_assembler
    import cc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [2:0]        idx_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic [LINE_W-1:0] line_o
);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (we_i) begin
            line_d[idx_i*BEAT_W +: BEAT_W] = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/cc_deserializer.sv
// Reassembles a critical-word-first 8-beat fill into natural order and pushes one
// 518-bit entry to the line-fill FIFO. CC_DESER_CWF_EN adds critical-word forwarding.
module cc_deserializer
    import cc_pkg::state_t, cc_pkg::S_IDLE, cc_pkg::S_RECV, cc_pkg::S_PUSH,
           cc_pkg::LINE_W, cc_pkg::FIFO_W;
#(
    parameter int BEATS  = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [2:0]        req_word_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rlast_i,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic              fifo_full_i,
    output logic              fifo_wren_o,
    output logic [FIFO_W-1:0] fifo_wdata_o,
    output logic              proto_err_o,
`ifdef CC_DESER_CWF_EN
    output logic              cwf_valid_o,
    output logic [DATA_W-1:0] cwf_data_o,
`endif
    output state_t            dbg_state_o
);

    // The 3-bit beat counter and base index only make sense for an 8 x 64b line.
    if (BEATS != 8 || BEATS * DATA_W != LINE_W) begin : g_cfg_err
        $error("cc_deserializer: BEATS must be 8 and BEATS*DATA_W must equal 512");
    end

    // Handshake: a beat transfers on a cycle where mem_rvalid_i and mem_rready_o are
    // both high; a request transfers when req_valid_i and req_ready_o are both high.
    state_t      state_q, state_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic [2:0]  base_q, base_d;
    logic        proto_err_q, proto_err_d;
    logic        beat_fire;
    logic [2:0]  wr_idx;
    logic [LINE_W-1:0] line_buf;

    assign wr_idx = base_q + beat_cnt_q;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        base_d       = base_q;
        proto_err_d  = proto_err_q;
        req_ready_o  = 1'b0;
        mem_rready_o = 1'b0;
        fifo_wren_o  = 1'b0;
        beat_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    base_d     = req_word_i;
                    beat_cnt_d = 3'd0;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                mem_rready_o = 1'b1;
                beat_fire    = mem_rvalid_i;
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    // rlast must coincide exactly with the eighth beat; assembly stays count-based.
                    if (mem_rlast_i != (beat_cnt_q == 3'd7)) begin
                        proto_err_d = 1'b1;
                    end
                    if (beat_cnt_q == 3'd7) begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                fifo_wren_o = ~fifo_full_i;
                if (!fifo_full_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= 3'd0;
            base_q      <= 3'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            base_q      <= base_d;
            proto_err_q <= proto_err_d;
        end
    end

    cc_line_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .we_i   (beat_fire),
        .idx_i  (wr_idx),
        .data_i (mem_rdata_i),
        .line_o (line_buf)
    );

    assign fifo_wdata_o = (state_q == S_PUSH) ? {base_q, 3'b000, line_buf} : '0;
    assign proto_err_o  = proto_err_q;
    assign dbg_state_o  = state_q;

`ifdef CC_DESER_CWF_EN
    logic              cwf_valid_q;
    logic [DATA_W-1:0] cwf_data_q;
    logic              cwf_hit;

    assign cwf_hit = beat_fire && (beat_cnt_q == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cwf_valid_q <= 1'b0;
            cwf_data_q  <= '0;
        end else begin
            cwf_valid_q <= cwf_hit;
            cwf_data_q  <= cwf_hit ? mem_rdata_i : '0;
        end
    end

    assign cwf_valid_o = cwf_valid_q;
    assign cwf_data_o  = cwf_data_q;
`endif

endmodule

// File: tb/tb_cc_deserializer.sv
// Directed bench for cc_deserializer: ordering, FIFO back-pressure, rlast errors,
// mid-line reset and (with CC_DESER_CWF_EN) critical-word forwarding.
module tb_cc_deserializer;
    import cc_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_i = 1'b0;
    logic [2:0]        req_word_i = 3'd0;
    logic              req_ready_o;
    logic [63:0]       mem_rdata_i = '0;
    logic              mem_rlast_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic              mem_rready_o;
    logic              fifo_full_i = 1'b0;
    logic              fifo_wren_o;
    logic [FIFO_W-1:0] fifo_wdata_o;
    logic              proto_err_o;
    state_t            dbg_state_o;
`ifdef CC_DESER_CWF_EN
    logic              cwf_valid_o;
    logic [63:0]       cwf_data_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [FIFO_W-1:0] exp_q[$];
    logic [63:0]       beats_v[8];

    always #5 clk = ~clk;

    cc_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_word_i   (req_word_i),
        .req_ready_o  (req_ready_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_rlast_i  (mem_rlast_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rready_o (mem_rready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wren_o  (fifo_wren_o),
        .fifo_wdata_o (fifo_wdata_o),
        .proto_err_o  (proto_err_o),
`ifdef CC_DESER_CWF_EN
        .cwf_valid_o  (cwf_valid_o),
        .cwf_data_o   (cwf_data_o),
`endif
        .dbg_state_o  (dbg_state_o)
    );

    task automatic check_eq(input string tag, input logic [FIFO_W-1:0] obs,
                            input logic [FIFO_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FIFO_W-1:0] line_of(input logic [2:0] base);
        logic [FIFO_W-1:0] e;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            e[((int'(base) + i) % 8) * 64 +: 64] = beats_v[i];
        end
        e[517:515] = base;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_eq("rst_req_ready", req_ready_o, 1);
        check_eq("rst_rready", mem_rready_o, 0);
        check_eq("rst_wren", fifo_wren_o, 0);
        check_eq("rst_wdata", fifo_wdata_o, 0);
        check_eq("rst_err", proto_err_o, 0);
        check_eq("rst_state", dbg_state_o, S_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] base);
        int budget = 20;
        req_valid_i = 1'b1;
        req_word_i  = base;
        while (!req_ready_o && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("req_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input bit gaps);
        int budget = 50;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && budget > 0) begin
                tick();
                budget--;
            end
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        mem_rlast_i  = last;
        while (!mem_rready_o && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("beat_rready", mem_rready_o, 1);
        tick();
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
    endtask

    // Request plus eight beats with rlast only on the last; leaves DUT in the push cycle.
    task automatic start_line(input logic [2:0] base, input bit gaps);
        exp_q.push_back(line_of(base));
        do_req(base);
        for (int i = 0; i < 8; i++) begin
            send_beat(beats_v[i], i == 7, gaps);
        end
    endtask

    task automatic end_push();
        check_eq("push_wren", fifo_wren_o, 1);
        tick();
        check_eq("post_push_wren", fifo_wren_o, 0);
        check_eq("post_push_idle", req_ready_o, 1);
    endtask

    // Scoreboard: every FIFO write must match the oldest expected line.
    always @(negedge clk) begin
        if (fifo_wren_o) begin
            check_eq("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check_eq("wr_data", fifo_wdata_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // Base 0, data equals word index.
        for (int i = 0; i < 8; i++) beats_v[i] = 64'(i);
        start_line(3'd0, 1'b0);
        check_eq("t1_w0", fifo_wdata_o[63:0], 64'h0);
        check_eq("t1_w7", fifo_wdata_o[511:448], 64'h7);
        check_eq("t1_pad", fifo_wdata_o[514:512], 0);
        check_eq("t1_base", fifo_wdata_o[517:515], 0);
        check_eq("t1_err", proto_err_o, 0);
        end_push();

        // Base 5: words 5,6,7,0,1,2,3,4 carry A0..A7.
        for (int i = 0; i < 8; i++) beats_v[i] = 64'hA0 + 64'(i);
        start_line(3'd5, 1'b0);
        check_eq("t2_w5", fifo_wdata_o[383:320], 64'hA0);
        check_eq("t2_w0", fifo_wdata_o[63:0], 64'hA3);
        check_eq("t2_w4", fifo_wdata_o[319:256], 64'hA7);
        check_eq("t2_base", fifo_wdata_o[517:515], 5);
        end_push();

        // FIFO full for 6 cycles after the last beat.
        for (int i = 0; i < 8; i++) beats_v[i] = {$urandom(), $urandom()};
        fifo_full_i = 1'b1;
        start_line(3'd1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            check_eq("full_wren", fifo_wren_o, 0);
            check_eq("full_rready", mem_rready_o, 0);
            check_eq("full_req_ready", req_ready_o, 0);
            check_eq("full_wdata", fifo_wdata_o, line_of(3'd1));
            tick();
        end
        fifo_full_i = 1'b0;
        #1;
        end_push();

        // rlast early on beat index 3.
        for (int i = 0; i < 8; i++) beats_v[i] = 64'hB000 + 64'(i);
        exp_q.push_back(line_of(3'd2));
        do_req(3'd2);
        for (int i = 0; i < 8; i++) begin
            send_beat(beats_v[i], i == 3 || i == 7, 1'b0);
            if (i == 2) check_eq("early_err_before", proto_err_o, 0);
            if (i == 3) check_eq("early_err_set", proto_err_o, 1);
        end
        end_push();
        check_eq("early_err_sticky", proto_err_o, 1);
        do_reset();

        // rlast missing on the last beat.
        for (int i = 0; i < 8; i++) beats_v[i] = 64'hC000 + 64'(i);
        exp_q.push_back(line_of(3'd7));
        do_req(3'd7);
        for (int i = 0; i < 8; i++) begin
            send_beat(beats_v[i], 1'b0, 1'b0);
            if (i == 6) check_eq("miss_err_before", proto_err_o, 0);
        end
        check_eq("miss_err_set", proto_err_o, 1);
        end_push();
        do_reset();

        // Random gaps, reset after the fourth beat: no write for this line.
        do_req(3'd6);
        for (int i = 0; i < 4; i++) send_beat(64'hD000 + 64'(i), 1'b0, 1'b1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hD004;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rready", mem_rready_o, 0);
        check_eq("mid_rst_req_ready", req_ready_o, 1);
        check_eq("mid_rst_wren", fifo_wren_o, 0);
        check_eq("mid_rst_wdata", fifo_wdata_o, 0);
        check_eq("mid_rst_state", dbg_state_o, S_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_rvalid_i = 1'b0;
        check_eq("mid_rst_no_pending", exp_q.size(), 0);

        for (int i = 0; i < 8; i++) beats_v[i] = 64'hE0 + 64'(i);
        start_line(3'd2, 1'b1);
        check_eq("t6_w2", fifo_wdata_o[191:128], 64'hE0);
        check_eq("t6_w1", fifo_wdata_o[127:64], 64'hE7);
        check_eq("t6_base", fifo_wdata_o[517:515], 2);
        end_push();

`ifdef CC_DESER_CWF_EN
        check_eq("cwf_idle", cwf_valid_o, 0);
        beats_v[0] = 64'hDEAD;
        for (int i = 1; i < 8; i++) beats_v[i] = 64'hF0 + 64'(i);
        exp_q.push_back(line_of(3'd3));
        do_req(3'd3);
        send_beat(beats_v[0], 1'b0, 1'b0);
        check_eq("cwf_valid", cwf_valid_o, 1);
        check_eq("cwf_data", cwf_data_o, 64'hDEAD);
        for (int i = 1; i < 8; i++) begin
            send_beat(beats_v[i], i == 7, 1'b0);
            if (i == 1) check_eq("cwf_pulse_end", cwf_valid_o, 0);
        end
        check_eq("cwf_data_clr", cwf_data_o, 0);
        end_push();
`endif

        tick();
        tick();
        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("final_err", proto_err_o, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
